// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between decode and the branch resolution stage.
// The master drives the branch request; the slave returns the resolved result.
interface branch_resolve_unit_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [1:0]        branch_code;
  logic              signed_cmp;
  logic              pred_taken;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] fallthru_pc;
  logic              resolve_valid;
  logic              taken;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;

  modport master (
    output req_valid, op_a, op_b, branch_code, signed_cmp, pred_taken, target_pc, fallthru_pc,
    input  req_ready, resolve_valid, taken, mispredict, redirect_pc, flush
  );

  modport slave (
    input  req_valid, op_a, op_b, branch_code, signed_cmp, pred_taken, target_pc, fallthru_pc,
    output req_ready, resolve_valid, taken, mispredict, redirect_pc, flush
  );

endinterface

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: compare, check prediction, redirect and timed flush.
// Optional BRU_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_unit #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  branch_resolve_unit_if.slave   brq
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]            stat_resolved_o,
  output logic [15:0]            stat_mispredict_o
`endif
);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic              resolve_valid_q, resolve_valid_d;
  logic              taken_q, taken_d;
  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

  logic cmp_eq, cmp_gt, cmp_lt, cmp_taken;
  logic req_ready, accept, misp_now;

  // Ready depends only on registered state, never on req_valid.
  assign req_ready = (state_q == StIdle);
  assign accept    = brq.req_valid & req_ready;

  always_comb begin
    cmp_eq = (brq.op_a == brq.op_b);
    if (brq.signed_cmp) begin
      cmp_gt = ($signed(brq.op_a) > $signed(brq.op_b));
      cmp_lt = ($signed(brq.op_a) < $signed(brq.op_b));
    end else begin
      cmp_gt = (brq.op_a > brq.op_b);
      cmp_lt = (brq.op_a < brq.op_b);
    end
    cmp_taken = 1'b0;
    unique case (brq.branch_code)
      2'b00: cmp_taken = cmp_eq;
      2'b01: cmp_taken = cmp_gt;
      2'b10: cmp_taken = cmp_lt;
      2'b11: cmp_taken = ~cmp_eq;
      default: cmp_taken = 1'b0;
    endcase
  end

  assign misp_now = cmp_taken ^ brq.pred_taken;

  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    resolve_valid_d = 1'b0;
    taken_d         = taken_q;
    mispredict_d    = mispredict_q;
    redirect_pc_d   = redirect_pc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          resolve_valid_d = 1'b1;
          taken_d         = cmp_taken;
          mispredict_d    = misp_now;
          redirect_pc_d   = cmp_taken ? brq.target_pc : brq.fallthru_pc;
          if (misp_now) begin
            state_d     = StFlush;
            flush_cnt_d = FlushLoad;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      flush_cnt_q     <= 4'd0;
      resolve_valid_q <= 1'b0;
      taken_q         <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      resolve_valid_q <= resolve_valid_d;
      taken_q         <= taken_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  assign brq.req_ready     = req_ready;
  assign brq.resolve_valid = resolve_valid_q;
  assign brq.taken         = taken_q;
  assign brq.mispredict    = mispredict_q;
  assign brq.redirect_pc   = redirect_pc_q;
  // Flush window begins with the resolve cycle, so it is simply the FLUSH state.
  assign brq.flush         = (state_q == StFlush);

`ifdef BRU_STATS_EN
  logic [15:0] stat_res_q, stat_misp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_res_q  <= 16'd0;
      stat_misp_q <= 16'd0;
    end else begin
      if (resolve_valid_q && (stat_res_q != 16'hFFFF)) begin
        stat_res_q <= stat_res_q + 16'd1;
      end
      if (resolve_valid_q && mispredict_q && (stat_misp_q != 16'hFFFF)) begin
        stat_misp_q <= stat_misp_q + 16'd1;
      end
    end
  end

  assign stat_resolved_o   = stat_res_q;
  assign stat_mispredict_o = stat_misp_q;
`endif

endmodule
